sprite_rom_arbiter: RTL and testbench

- Shares one synchronous sprite-sheet ROM between NUM_REQ sprite pixel fetchers, for example player, NPCs and projectiles.
- Each fetcher supplies the sheet frame offsets (hoffset/voffset, as produced by the sprite select logic) and a pixel coordinate within the 16x16 frame.
- The block arbitrates round-robin, forms the linear ROM address, tracks the ROM latency, and returns the pixel tagged with the requester id.
- It sits between the per-sprite selectors and the shared sheet ROM in the video path.

---
 rtl/sprite_rom_arbiter_if.sv | 40 ++++
 rtl/sprite_rom_arbiter.sv | 138 +++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bundle of the sprite ROM arbiter: fetch requests, grants, pixel return.
// SPRITE_ARB_FLIP_EN adds the per-requester req_flip field.
interface sprite_rom_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*9-1:0] req_hoff;
    logic [NUM_REQ*9-1:0] req_voff;
    logic [NUM_REQ*4-1:0] req_px;
    logic [NUM_REQ*4-1:0] req_py;
`ifdef SPRITE_ARB_FLIP_EN
    logic [NUM_REQ-1:0]   req_flip;
`endif
    logic [NUM_REQ-1:0]   gnt;
    logic                 rd_valid;
    logic [ID_W-1:0]      rd_id;
    logic [DATA_W-1:0]    rd_data;

`ifdef SPRITE_ARB_FLIP_EN
    modport master (
        output req, req_hoff, req_voff, req_px, req_py, req_flip,
        input  gnt, rd_valid, rd_id, rd_data
    );
    modport slave (
        input  req, req_hoff, req_voff, req_px, req_py, req_flip,
        output gnt, rd_valid, rd_id, rd_data
    );
`else
    modport master (
        output req, req_hoff, req_voff, req_px, req_py,
        input  gnt, rd_valid, rd_id, rd_data
    );
    modport slave (
        input  req, req_hoff, req_voff, req_px, req_py,
        output gnt, rd_valid, rd_id, rd_data
    );
`endif
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite-sheet ROM between NUM_REQ pixel fetchers.
// Optional SPRITE_ARB_FLIP_EN mirrors px horizontally per request.
module sprite_rom_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int SHEET_W_LOG2 = 6,
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int ROM_LAT      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sprite_rom_arbiter_if.slave bus,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);
    localparam int SUM_W = ADDR_W + 1;

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    win;
    logic [ID_W:0]      scan;
    logic               found;
    logic [NUM_REQ-1:0] gnt_c;

    logic [8:0]         sel_hoff;
    logic [8:0]         sel_voff;
    logic [3:0]         sel_px;
    logic [3:0]         sel_py;
    logic [3:0]         px_eff;
    logic [SUM_W-1:0]   row;
    logic [SUM_W-1:0]   col;
    logic [ADDR_W-1:0]  addr_n;

    logic [ROM_LAT:0]   v_pipe;
    logic [ID_W-1:0]    id_pipe [ROM_LAT+1];
    logic               rd_valid_q;
    logic [ID_W-1:0]    rd_id_q;
    logic [DATA_W-1:0]  rd_data_q;

    // Rotating scan starting at ptr, first requester found wins
    always_comb begin
        gnt_c = '0;
        win   = '0;
        found = 1'b0;
        scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(NUM_REQ))
                scan = scan - (ID_W+1)'(NUM_REQ);
            if (!found && bus.req[scan[ID_W-1:0]]) begin
                found = 1'b1;
                win   = scan[ID_W-1:0];
            end
        end
        if (found)
            gnt_c[win] = 1'b1;
    end

    assign bus.gnt = gnt_c;

`ifdef SPRITE_ARB_FLIP_EN
    logic sel_flip;
`endif

    always_comb begin
        sel_hoff = '0;
        sel_voff = '0;
        sel_px   = '0;
        sel_py   = '0;
`ifdef SPRITE_ARB_FLIP_EN
        sel_flip = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) begin
                sel_hoff = bus.req_hoff[9*i +: 9];
                sel_voff = bus.req_voff[9*i +: 9];
                sel_px   = bus.req_px[4*i +: 4];
                sel_py   = bus.req_py[4*i +: 4];
`ifdef SPRITE_ARB_FLIP_EN
                sel_flip = bus.req_flip[i];
`endif
            end
        end
    end

`ifdef SPRITE_ARB_FLIP_EN
    assign px_eff = sel_flip ? (4'd15 - sel_px) : sel_px;
`else
    assign px_eff = sel_px;
`endif

    // Linear sheet address; wraps silently modulo 2^ADDR_W
    assign row    = SUM_W'(sel_voff) + SUM_W'(sel_py);
    assign col    = SUM_W'(sel_hoff) + SUM_W'(px_eff);
    assign addr_n = ADDR_W'((row << SHEET_W_LOG2) + col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
        end else begin
            rom_en <= found;
            if (found) begin
                rom_addr <= addr_n;
                ptr      <= (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
            end
        end
    end

    // Stage 0 tracks rom_en; stage ROM_LAT lines up with rom_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_pipe     <= '0;
            for (int k = 0; k <= ROM_LAT; k++)
                id_pipe[k] <= '0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
            rd_data_q  <= '0;
        end else begin
            v_pipe     <= {v_pipe[ROM_LAT-1:0], found};
            id_pipe[0] <= win;
            for (int k = 1; k <= ROM_LAT; k++)
                id_pipe[k] <= id_pipe[k-1];
            rd_valid_q <= v_pipe[ROM_LAT];
            if (v_pipe[ROM_LAT]) begin
                rd_id_q   <= id_pipe[ROM_LAT];
                rd_data_q <= rom_data;
            end
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_id    = rd_id_q;
    assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: vector table plus return scoreboard.
// Flip vectors run only when SPRITE_ARB_FLIP_EN is defined.
module tb_sprite_rom_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int ROM_LAT = 1;

    typedef struct {
        logic [3:0]  req;
        logic [35:0] hoff;
        logic [35:0] voff;
        logic [15:0] px;
        logic [15:0] py;
        logic [3:0]  flip;
        logic [3:0]  exp_gnt;
        logic [11:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] rom_d [ROM_LAT];

    sprite_rom_arbiter_if #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W)
    ) bus ();

    sprite_rom_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .SHEET_W_LOG2(6),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        rom_d[0] <= rom_fn(rom_addr);
        for (int k = 1; k < ROM_LAT; k++)
            rom_d[k] <= rom_d[k-1];
    end
    assign rom_data = rom_d[ROM_LAT-1];

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    exp_t       sb[$];
    logic       exp_en = 1'b0;
    logic [11:0] exp_addr = '0;
    logic [7:0] exp_rd = '0;
    vec_t       tbl[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic int addr_fn(input int h, v, x, y);
        return ((v + y) * 64 + h + x) % 4096;
    endfunction

    function automatic vec_t mk(input logic [3:0] r, input int id,
                                input int h, v, x, y, f,
                                input logic [3:0] g, input int a);
        vec_t t;
        for (int k = 0; k < 4; k++) begin
            t.hoff[9*k +: 9] = 9'(37*k + 11);
            t.voff[9*k +: 9] = 9'(53*k + 7);
            t.px[4*k +: 4]   = 4'(k + 9);
            t.py[4*k +: 4]   = 4'(2*k + 1);
            t.flip[k]        = 1'b0;
        end
        t.hoff[9*id +: 9] = 9'(h);
        t.voff[9*id +: 9] = 9'(v);
        t.px[4*id +: 4]   = 4'(x);
        t.py[4*id +: 4]   = 4'(y);
        t.flip[id]        = 1'(f);
        t.req      = r;
        t.exp_gnt  = g;
        t.exp_addr = 12'(a);
        return t;
    endfunction

    task automatic drive(input vec_t v);
        bus.req      = v.req;
        bus.req_hoff = v.hoff;
        bus.req_voff = v.voff;
        bus.req_px   = v.px;
        bus.req_py   = v.py;
`ifdef SPRITE_ARB_FLIP_EN
        bus.req_flip = v.flip;
`endif
    endtask

    task automatic check_outs();
        logic due;
        exp_t e;
        due = (sb.size() > 0) && (sb[0].due <= cyc);
        chk("rom_en", 32'(rom_en), 32'(exp_en));
        chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
        chk("rd_valid", 32'(bus.rd_valid), 32'(due));
        if (due) begin
            e = sb.pop_front();
            exp_rd = e.data;
            chk("rd_id", 32'(bus.rd_id), 32'(e.id));
        end
        chk("rd_data", 32'(bus.rd_data), 32'(exp_rd));
    endtask

    task automatic cycle(input vec_t v);
        exp_t e;
        @(negedge clk);
        cyc++;
        check_outs();
        drive(v);
        #1;
        chk("gnt", 32'(bus.gnt), 32'(v.exp_gnt));
        exp_en = (v.exp_gnt != 4'b0000);
        if (exp_en) begin
            exp_addr = v.exp_addr;
            e.id = 2'd0;
            for (int k = 0; k < 4; k++)
                if (v.exp_gnt[k]) e.id = 2'(k);
            e.data = rom_fn(v.exp_addr);
            e.due  = cyc + ROM_LAT + 2;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        drive(mk(4'hF, 0, 0, 0, 0, 0, 0, 4'h0, 0));
        sb.delete();
        exp_en   = 1'b0;
        exp_addr = '0;
        exp_rd   = '0;
        repeat (n) begin
            #1;
            chk("rst_gnt", 32'(bus.gnt), 32'h1);
            chk("rst_rom_en", 32'(rom_en), 32'h0);
            chk("rst_rom_addr", 32'(rom_addr), 32'h0);
            chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
            chk("rst_rd_data", 32'(bus.rd_data), 32'h0);
            @(negedge clk);
        end
        rst_n   = 1'b1;
        bus.req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        rst_n = 1'b0;
        idle  = mk(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        drive(idle);

        tbl[0]  = mk(4'b1111, 0,  16,  32,  3,  5, 0, 4'b0001, 12'h953);
        tbl[1]  = mk(4'b0000, 0,   0,   0,  0,  0, 0, 4'b0000, 0);
        tbl[2]  = mk(4'b1001, 3,   0,   0,  0,  0, 0, 4'b1000, 0);
        tbl[3]  = mk(4'b1001, 0,  63,   1, 15,  0, 0, 4'b0001, 142);
        tbl[4]  = mk(4'b0101, 2, 100,  10,  7,  9, 0, 4'b0100, 1323);
        tbl[5]  = mk(4'b0011, 0,   5,   5,  5,  5, 0, 4'b0001, 650);
        tbl[6]  = mk(4'b0011, 1, 511, 511, 15, 15, 0, 4'b0010, 1422);
        tbl[7]  = mk(4'b0011, 0,   0,  63,  0,  1, 0, 4'b0001, 0);
        tbl[8]  = mk(4'b1110, 1,  32,   0,  1,  0, 0, 4'b0010, 33);
        tbl[9]  = mk(4'b1100, 2,   1,   2,  3,  4, 0, 4'b0100, 388);
        tbl[10] = mk(4'b1000, 3,   9,   9,  9,  9, 0, 4'b1000, 1170);

        do_reset(3);

        for (int i = 0; i < 11; i++)
            cycle(tbl[i]);

        // Fairness: all requesters held, rotation from ptr 0
        for (int i = 0; i < 8; i++) begin
            int id;
            id = i % 4;
            cycle(mk(4'b1111, id, 8*id, id, id, id, 0,
                     4'(1 << id), addr_fn(8*id, id, id, id)));
        end

        // Requester 2 streams a full frame row back-to-back
        for (int x = 0; x < 16; x++)
            cycle(mk(4'b0100, 2, 40, 7, x, 2, 0, 4'b0100,
                     addr_fn(40, 7, x, 2)));

`ifdef SPRITE_ARB_FLIP_EN
        cycle(mk(4'b0001, 0, 48, 0, 2, 0, 1, 4'b0001, 61));
        cycle(mk(4'b0001, 0, 48, 0, 2, 0, 0, 4'b0001, 50));
`endif

        // Reset one cycle after rom_en drops the outstanding read
        cycle(mk(4'b0001, 0, 1, 1, 1, 1, 0, 4'b0001, 130));
        cycle(idle);
        do_reset(2);
        repeat (6) cycle(idle);

        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
